seq_restoring_divider: RTL and testbench

- Iterative unsigned restoring divider: the division-side counterpart of the carry-save multiplier datapath.
- Produces quotient and remainder of WIDTH-bit operands, one quotient bit per clock.
- Start/done handshake towards the arithmetic controller.
- Datapath: one (WIDTH+1)-bit trial subtractor, shift registers and a step counter.

---
 rtl/seq_restoring_divider.sv | 104 ++++++++++
 tb/tb_seq_restoring_divider.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Start/done handshake; divide-by-zero is flagged and answered in one cycle.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t           state;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   t;
    logic [WIDTH:0]   r_nx;
    logic [WIDTH-1:0] q_nx;

    // One restoring step: shift {R,Q} left, trial-subtract D, keep or restore.
    always_comb begin
        r_sh = {r[WIDTH-1:0], q[WIDTH-1]};
        t    = r_sh - {1'b0, d};
        r_nx = r_sh;
        q_nx = {q[WIDTH-2:0], 1'b0};
        if (!t[WIDTH]) begin
            r_nx = t;
            q_nx = {q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor != '0) begin
                            d           <= divisor;
                            q           <= dividend;
                            r           <= '0;
                            cnt         <= CW'(WIDTH - 1);
                            div_by_zero <= 1'b0;
                            state       <= RUN;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= FIN;
                        end
                    end
                end
                RUN: begin
                    r   <= r_nx;
                    q   <= q_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        quotient  <= q_nx;
                        remainder <= r_nx[WIDTH-1:0];
                        done      <= 1'b1;
                        state     <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases plus
// a random sweep checked against plain / and % arithmetic.
module tb_seq_restoring_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one operation from an IDLE cycle and check the full handshake.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hammer);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        int           lat;
        int           k;
        ez  = (b == 0);
        eq  = ez ? {W{1'b1}} : W'(int'(a) / int'(b));
        er  = ez ? a : W'(int'(a) % int'(b));
        lat = ez ? 1 : W + 1;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        k = 1;
        while (done !== 1'b1 && k < lat + 4) begin
            chk("busy_run", busy, 1);
            if (hammer && k >= 3) begin
                start    = 1'b1;
                dividend = 50;
                divisor  = 3;
            end
            @(posedge clk);
            #1;
            k++;
        end
        chk("done_latency", k, lat);
        chk("busy_at_done", busy, 1);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", div_by_zero, ez);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_pulse_end", done, 0);
        chk("busy_idle", busy, 0);
        if (hammer) begin
            repeat (3) begin
                @(posedge clk);
                #1;
                chk("no_second_done", done, 0);
                chk("busy_ignored", busy, 0);
                chk("quotient_held", quotient, eq);
                chk("remainder_held", remainder, er);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(100, 7, 1'b0);
        run_op(255, 1, 1'b0);
        run_op(7, 9, 1'b0);
        run_op(5, 0, 1'b0);
        run_op(200, 200, 1'b0);
        run_op(100, 7, 1'b1);

        // Asynchronous reset in the middle of RUN cycle 4.
        dividend = 123;
        divisor  = 10;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_dbz", div_by_zero, 0);
        repeat (12) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", done, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op(200, 13, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            int sa;
            int sb;
            sa = $urandom_range(0, 9);
            sb = $urandom_range(0, 9);
            a  = (sa == 0) ? W'(0) : (sa == 1) ? W'(255) : W'($urandom);
            b  = (sb == 0) ? W'(0) : (sb == 1) ? W'(255) : (sb == 2) ? W'(1) : W'($urandom);
            run_op(a, b, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
